// File: rtl/command_arbiter_pkg.sv
// rtl/command_arbiter_pkg.sv - CAPI/PSL interface types, arbiter state encoding and parity helper.
package command_arbiter_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } arb_state;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic        tag_parity;
    logic [12:0] command;
    logic        command_parity;
    logic [2:0]  abt;
    logic [63:0] address;
    logic        address_parity;
    logic [15:0] context_handle;
    logic [11:0] size;
  } CommandInterfaceOutput;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic       tag_parity;
    logic [7:0] response;
  } ResponseInterface;

  typedef struct packed {
    logic         write_valid;
    logic [7:0]   write_tag;
    logic         write_tag_parity;
    logic [5:0]   write_address;
    logic [511:0] write_data;
    logic [7:0]   write_parity;
    logic         read_valid;
    logic [7:0]   read_tag;
    logic         read_tag_parity;
    logic [5:0]   read_address;
  } BufferInterfaceInput;

  typedef struct packed {
    logic [3:0]   read_latency;
    logic [511:0] read_data;
    logic [7:0]   read_parity;
  } BufferInterfaceOutput;

  // Odd parity per 64-bit doubleword; bit j covers data[64j+63:64j].
  function automatic logic [7:0] odd_parity_512(input logic [511:0] data);
    logic [7:0] p;
    for (int j = 0; j < 8; j++) p[j] = ~^data[64*j +: 64];
    return p;
  endfunction

endpackage

// File: rtl/command_arbiter_rr_picker.sv
// rtl/command_arbiter_rr_picker.sv - combinational round-robin picker, first valid at or after pointer.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant,
  output logic                 found
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;

  // N is a power of two, so the index wraps by plain truncation.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = pointer + PW'(k);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/command_arbiter.sv
// rtl/command_arbiter.sv - PSL command/response/buffer port sharer with round-robin grant and tag remap.
// Optional CMD_ARB_TAG_CHECK_EN adds a per-requester outstanding-tag bitmap and tag_error.
module command_arbiter
  import command_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CREDITS = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enabled,
  output logic                  drained,
  input  CommandInterfaceOutput req_command [NUM_REQ],
  output logic [NUM_REQ-1:0]    req_grant,
  output CommandInterfaceOutput command_out,
  input  ResponseInterface      response,
  output ResponseInterface      req_response [NUM_REQ],
  input  BufferInterfaceInput   buffer_in,
  output BufferInterfaceInput   req_buffer_in [NUM_REQ],
  input  logic [511:0]          req_read_data [NUM_REQ],
  output BufferInterfaceOutput  buffer_out
`ifdef CMD_ARB_TAG_CHECK_EN
  ,
  output logic                  tag_error
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int LW  = 8 - IDW;
  localparam int CW  = $clog2(CREDITS + 1);
  localparam int NLT = 1 << LW;

  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_IDLE  = IDLE;

  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  logic [1:0]            state;
  logic [CW-1:0]         credit;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        grant_id;
  logic [IDW-1:0]        id_q;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    pick;
  logic                  found;
  logic                  grant_fire;
  logic                  resp_ok;
  CommandInterfaceOutput sel_cmd;
  CommandInterfaceOutput next_cmd;

  wire [IDW-1:0] resp_id = response.tag[7:LW];
  wire [IDW-1:0] wr_id   = buffer_in.write_tag[7:LW];
  wire [IDW-1:0] rd_id   = buffer_in.read_tag[7:LW];
  wire [7:0] resp_ltag   = {{IDW{1'b0}}, response.tag[LW-1:0]};
  wire [7:0] wr_ltag     = {{IDW{1'b0}}, buffer_in.write_tag[LW-1:0]};
  wire [7:0] rd_ltag     = {{IDW{1'b0}}, buffer_in.read_tag[LW-1:0]};

`ifdef CMD_ARB_TAG_CHECK_EN
  logic [NLT-1:0] outstanding [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_command[i].valid && !outstanding[i][req_command[i].tag[LW-1:0]];
    resp_ok = outstanding[resp_id][response.tag[LW-1:0]];
  end

  // A grant and a clearing response can never target the same bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) outstanding[i] <= '0;
      tag_error <= 1'b0;
    end else begin
      if (grant_fire) outstanding[grant_id][sel_cmd.tag[LW-1:0]] <= 1'b1;
      if (response.valid) begin
        if (resp_ok) outstanding[resp_id][response.tag[LW-1:0]] <= 1'b0;
        else         tag_error <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) eligible[i] = req_command[i].valid;
    resp_ok = 1'b1;
  end
`endif

  rr_picker #(.N(NUM_REQ)) u_rr_picker (
    .valid   (eligible),
    .pointer (rr_ptr),
    .grant   (pick),
    .found   (found)
  );

  // Grant is combinational, so it is gated by reset_n to read zero during reset.
  assign grant_fire = reset_n && (state == ST_RUN) && (credit != '0) && found;
  assign req_grant  = grant_fire ? pick : '0;
  assign drained    = (state == ST_IDLE);

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) grant_id = IDW'(i);
  end

  always_comb begin
    sel_cmd                 = req_command[grant_id];
    next_cmd                = sel_cmd;
    next_cmd.valid          = 1'b1;
    next_cmd.tag            = {grant_id, sel_cmd.tag[LW-1:0]};
    next_cmd.tag_parity     = ~^next_cmd.tag;
    next_cmd.command_parity = ~^sel_cmd.command;
    next_cmd.address_parity = ~^sel_cmd.address;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      command_out <= '0;
    end else if (grant_fire) begin
      command_out <= next_cmd;
    end else begin
      command_out.valid <= 1'b0;
    end
  end

  // A response at full credit is dropped from the count rather than overflowing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credit <= CREDIT_MAX;
    end else if (grant_fire && !response.valid) begin
      credit <= credit - 1'b1;
    end else if (!grant_fire && response.valid && credit != CREDIT_MAX) begin
      credit <= credit + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= grant_id + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (!enabled) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (enabled)                   state <= ST_RUN;
          else if (credit == CREDIT_MAX) state <= ST_IDLE;
        end
        ST_IDLE:  if (enabled) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_response[i]            = response;
      req_response[i].tag        = resp_ltag;
      req_response[i].tag_parity = ~^resp_ltag;
      req_response[i].valid      = reset_n && response.valid && resp_ok && (resp_id == IDW'(i));

      req_buffer_in[i]                  = buffer_in;
      req_buffer_in[i].write_tag        = wr_ltag;
      req_buffer_in[i].write_tag_parity = ~^wr_ltag;
      req_buffer_in[i].write_valid      = reset_n && buffer_in.write_valid && (wr_id == IDW'(i));
      req_buffer_in[i].read_tag         = rd_ltag;
      req_buffer_in[i].read_tag_parity  = ~^rd_ltag;
      req_buffer_in[i].read_valid       = reset_n && buffer_in.read_valid && (rd_id == IDW'(i));
    end
  end

  // Requesters return read data one cycle after read_valid; hold the owner id for that cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q <= '0;
    end else if (buffer_in.read_valid) begin
      id_q <= rd_id;
    end
  end

  always_comb begin
    buffer_out.read_latency = 4'd1;
    buffer_out.read_data    = req_read_data[id_q];
    buffer_out.read_parity  = odd_parity_512(req_read_data[id_q]);
  end

endmodule

// File: tb/tb_command_arbiter.sv
// tb/tb_command_arbiter.sv - directed self-checking bench for command_arbiter (CREDITS=8 and CREDITS=2 instances).
module tb_command_arbiter;
  import command_arbiter_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  enabled;
  CommandInterfaceOutput req_command [4];
  ResponseInterface      response;
  BufferInterfaceInput   buffer_in;
  logic [511:0]          req_read_data [4];

  logic                  drained, c2_drained;
  logic [3:0]            req_grant, c2_grant;
  CommandInterfaceOutput command_out, c2_command_out;
  ResponseInterface      req_response [4];
  ResponseInterface      c2_req_response [4];
  BufferInterfaceInput   req_buffer_in [4];
  BufferInterfaceInput   c2_req_buffer_in [4];
  BufferInterfaceOutput  buffer_out, c2_buffer_out;
`ifdef CMD_ARB_TAG_CHECK_EN
  logic                  tag_error, c2_tag_error;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  command_arbiter #(.NUM_REQ(4), .CREDITS(8)) dut (
    .clock(clock), .reset_n(reset_n), .enabled(enabled), .drained(drained),
    .req_command(req_command), .req_grant(req_grant), .command_out(command_out),
    .response(response), .req_response(req_response),
    .buffer_in(buffer_in), .req_buffer_in(req_buffer_in),
    .req_read_data(req_read_data), .buffer_out(buffer_out)
`ifdef CMD_ARB_TAG_CHECK_EN
    , .tag_error(tag_error)
`endif
  );

  command_arbiter #(.NUM_REQ(4), .CREDITS(2)) dut_c2 (
    .clock(clock), .reset_n(reset_n), .enabled(enabled), .drained(c2_drained),
    .req_command(req_command), .req_grant(c2_grant), .command_out(c2_command_out),
    .response(response), .req_response(c2_req_response),
    .buffer_in(buffer_in), .req_buffer_in(c2_req_buffer_in),
    .req_read_data(req_read_data), .buffer_out(c2_buffer_out)
`ifdef CMD_ARB_TAG_CHECK_EN
    , .tag_error(c2_tag_error)
`endif
  );

  function automatic logic [3:0] resp_valids();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = req_response[i].valid;
    return r;
  endfunction

  function automatic logic [3:0] wr_valids();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = req_buffer_in[i].write_valid;
    return r;
  endfunction

  function automatic logic [3:0] rd_valids();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = req_buffer_in[i].read_valid;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) req_command[i] = '0;
    response  = '0;
    buffer_in = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    enabled = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    enabled = 1'b1;
    reset_n = 1'b0;
    req_command[0].valid  = 1'b1;
    response.valid        = 1'b1;
    response.tag          = 8'h40;
    buffer_in.write_valid = 1'b1;
    #23;
    n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", req_grant); end
    n_checks++; if (command_out.valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got=%b exp=0", command_out.valid); end
    n_checks++; if ({command_out.tag, command_out.command, command_out.address} !== '0) begin n_fail++; $display("FAIL reset_cmd_fields got tag=%h cmd=%h addr=%h exp 0", command_out.tag, command_out.command, command_out.address); end
    n_checks++; if (resp_valids() !== 4'b0000) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valids()); end
    n_checks++; if (wr_valids() !== 4'b0000) begin n_fail++; $display("FAIL reset_buf_valid got=%b exp=0000", wr_valids()); end
    n_checks++; if (drained !== 1'b0 || c2_drained !== 1'b0) begin n_fail++; $display("FAIL reset_drained got=%b/%b exp=0/0", drained, c2_drained); end
    n_checks++; if (dut.credit !== 4'd8) begin n_fail++; $display("FAIL reset_credit got=%0d exp=8", dut.credit); end
    n_checks++; if (dut_c2.credit !== 2'd2) begin n_fail++; $display("FAIL reset_credit_c2 got=%0d exp=2", dut_c2.credit); end
    n_checks++; if (dut.rr_ptr !== 2'd0 || dut.state !== 2'd0) begin n_fail++; $display("FAIL reset_ptr_state got ptr=%0d state=%0d exp 0/0", dut.rr_ptr, dut.state); end
    n_checks++; if (c2_grant !== 4'b0000 || c2_command_out.valid !== 1'b0) begin n_fail++; $display("FAIL reset_c2_out got grant=%b valid=%b exp 0", c2_grant, c2_command_out.valid); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    tick();
    req_command[1].valid   = 1'b1;
    req_command[1].tag     = 8'h05;
    req_command[1].size    = 12'd128;
    req_command[1].command = 13'h0A00;
    req_command[1].address = 64'h1000;
    sample();
    n_checks++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant got=%b exp=0010", req_grant); end
    tick();
    req_command[1] = '0;
    sample();
    n_checks++; if (command_out.valid !== 1'b1 || command_out.tag !== 8'h45) begin n_fail++; $display("FAIL single_cmd got valid=%b tag=%h exp 1/45", command_out.valid, command_out.tag); end
    n_checks++; if (command_out.size !== 12'd128 || command_out.address !== 64'h1000) begin n_fail++; $display("FAIL single_fields got size=%0d addr=%h exp 128/1000", command_out.size, command_out.address); end
    n_checks++; if ({command_out.tag_parity, command_out.command_parity, command_out.address_parity} !== 3'b010) begin n_fail++; $display("FAIL single_parity got=%b exp=010", {command_out.tag_parity, command_out.command_parity, command_out.address_parity}); end
    tick();
    response.valid = 1'b1;
    response.tag   = 8'h45;
    sample();
    n_checks++; if (command_out.valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle got valid=%b exp=0", command_out.valid); end
    n_checks++; if (resp_valids() !== 4'b0010 || req_response[1].tag !== 8'h05) begin n_fail++; $display("FAIL single_resp got valids=%b tag=%h exp 0010/05", resp_valids(), req_response[1].tag); end
    tick();
    response = '0;
  endtask

  task automatic test_contention();
    logic [7:0] ltag [4];
    logic [7:0] et;
    int g;
    do_reset();
    et = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      ltag[i] = 8'(i + 1);
      req_command[i].valid = 1'b1;
      req_command[i].tag   = ltag[i];
    end
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      sample();
      n_checks++; if (req_grant !== 4'(1 << g)) begin n_fail++; $display("FAIL contention_grant%0d got=%b exp=%b", k, req_grant, 4'(1 << g)); end
      if (k > 0) begin
        n_checks++; if (command_out.valid !== 1'b1 || command_out.tag !== et) begin n_fail++; $display("FAIL contention_tag%0d got valid=%b tag=%h exp 1/%h", k, command_out.valid, command_out.tag, et); end
      end
      et = {2'(g), ltag[g][5:0]};
      tick();
      ltag[g] = ltag[g] + 8'd8;
      req_command[g].tag = ltag[g];
    end
    sample();
    n_checks++; if (command_out.tag !== et) begin n_fail++; $display("FAIL contention_wrap_tag got=%h exp=%h", command_out.tag, et); end
    clear_inputs();
  endtask

  task automatic test_credits();
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) req_command[i].valid = 1'b1;
    sample();
    n_checks++; if (c2_grant !== 4'b0001) begin n_fail++; $display("FAIL credit_g0 got=%b exp=0001", c2_grant); end
    tick(); req_command[0].valid = 1'b0;
    sample();
    n_checks++; if (c2_grant !== 4'b0010) begin n_fail++; $display("FAIL credit_g1 got=%b exp=0010", c2_grant); end
    tick(); req_command[1].valid = 1'b0;
    sample();
    n_checks++; if (c2_grant !== 4'b0000) begin n_fail++; $display("FAIL credit_stall0 got=%b exp=0000", c2_grant); end
    tick();
    sample();
    n_checks++; if (c2_grant !== 4'b0000) begin n_fail++; $display("FAIL credit_stall1 got=%b exp=0000", c2_grant); end
    tick(); response.valid = 1'b1; response.tag = 8'h00;
    sample();
    n_checks++; if (c2_grant !== 4'b0000) begin n_fail++; $display("FAIL credit_resp_cycle got=%b exp=0000", c2_grant); end
    tick(); response = '0;
    sample();
    n_checks++; if (c2_grant !== 4'b0100) begin n_fail++; $display("FAIL credit_third got=%b exp=0100", c2_grant); end
    tick(); req_command[2].valid = 1'b0; response.valid = 1'b1; response.tag = 8'h40;
    sample();
    tick(); response.tag = 8'h80; req_command[3].valid = 1'b1;
    sample();
    n_checks++; if (c2_grant !== 4'b1000) begin n_fail++; $display("FAIL credit_same_cycle got=%b exp=1000", c2_grant); end
    tick(); response = '0; req_command[3].valid = 1'b0; req_command[0].valid = 1'b1;
    sample();
    n_checks++; if (c2_grant !== 4'b0001) begin n_fail++; $display("FAIL credit_kept got=%b exp=0001", c2_grant); end
    tick(); req_command[0].valid = 1'b0; req_command[1].valid = 1'b1;
    sample();
    n_checks++; if (c2_grant !== 4'b0000) begin n_fail++; $display("FAIL credit_exhausted got=%b exp=0000", c2_grant); end
    clear_inputs();
  endtask

  task automatic test_buffer();
    do_reset();
    for (int i = 0; i < 4; i++) req_read_data[i] = {16{32'h1000_0000 + 32'(i)}};
    req_read_data[3] = {64'h3, 64'h1, 64'h3, 64'h1, 64'h3, 64'h1, 64'h3, 64'h1};
    tick();
    buffer_in.write_valid   = 1'b1;
    buffer_in.write_tag     = 8'h82;
    buffer_in.write_address = 6'd1;
    sample();
    n_checks++; if (wr_valids() !== 4'b0100) begin n_fail++; $display("FAIL buf_write_route got=%b exp=0100", wr_valids()); end
    n_checks++; if (req_buffer_in[2].write_tag !== 8'h02 || req_buffer_in[2].write_address !== 6'd1) begin n_fail++; $display("FAIL buf_write_tag got tag=%h addr=%0d exp 02/1", req_buffer_in[2].write_tag, req_buffer_in[2].write_address); end
    tick();
    buffer_in = '0;
    buffer_in.read_valid = 1'b1;
    buffer_in.read_tag   = 8'hC0;
    sample();
    n_checks++; if (rd_valids() !== 4'b1000 || req_buffer_in[3].read_tag !== 8'h00) begin n_fail++; $display("FAIL buf_read_route got valids=%b tag=%h exp 1000/00", rd_valids(), req_buffer_in[3].read_tag); end
    tick();
    buffer_in = '0;
    sample();
    n_checks++; if (buffer_out.read_data !== {64'h3, 64'h1, 64'h3, 64'h1, 64'h3, 64'h1, 64'h3, 64'h1}) begin n_fail++; $display("FAIL buf_read_data got=%h exp req_read_data[3]", buffer_out.read_data[127:0]); end
    n_checks++; if (buffer_out.read_parity !== 8'hAA || buffer_out.read_latency !== 4'd1) begin n_fail++; $display("FAIL buf_read_parity got par=%h lat=%0d exp AA/1", buffer_out.read_parity, buffer_out.read_latency); end
  endtask

  task automatic test_drain();
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) req_command[i].valid = 1'b1;
    sample();
    tick(); req_command[0].valid = 1'b0;
    sample();
    tick(); req_command[1].valid = 1'b0;
    sample();
    n_checks++; if (req_grant !== 4'b0100) begin n_fail++; $display("FAIL drain_third_grant got=%b exp=0100", req_grant); end
    tick(); req_command[2].valid = 1'b0; enabled = 1'b0;
    sample();
    tick(); req_command[3].valid = 1'b1;
    sample();
    n_checks++; if (req_grant !== 4'b0000 || drained !== 1'b0) begin n_fail++; $display("FAIL drain_block got grant=%b drained=%b exp 0000/0", req_grant, drained); end
    tick(); response.valid = 1'b1; response.tag = 8'h00;
    tick(); response.tag = 8'h40;
    tick(); response.tag = 8'h80;
    sample();
    n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL drain_early got=%b exp=0", drained); end
    tick(); response = '0;
    sample();
    n_checks++; if (drained !== 1'b0 || req_grant !== 4'b0000) begin n_fail++; $display("FAIL drain_pre_idle got drained=%b grant=%b exp 0/0000", drained, req_grant); end
    tick();
    sample();
    n_checks++; if (drained !== 1'b1 || req_grant !== 4'b0000) begin n_fail++; $display("FAIL drain_idle got drained=%b grant=%b exp 1/0000", drained, req_grant); end
    tick(); enabled = 1'b1;
    sample();
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL drain_hold got=%b exp=1", drained); end
    tick();
    sample();
    n_checks++; if (drained !== 1'b0 || req_grant !== 4'b1000) begin n_fail++; $display("FAIL drain_resume got drained=%b grant=%b exp 0/1000", drained, req_grant); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    req_command[0].valid = 1'b1;
    req_command[0].tag   = 8'h01;
    sample();
    tick();
    req_command[0]       = '0;
    req_command[1].valid = 1'b1;
    response.valid       = 1'b1;
    response.tag         = 8'h01;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (command_out.valid !== 1'b0 || command_out.tag !== 8'h00) begin n_fail++; $display("FAIL midreset_cmd got valid=%b tag=%h exp 0/00", command_out.valid, command_out.tag); end
    n_checks++; if (req_grant !== 4'b0000 || resp_valids() !== 4'b0000) begin n_fail++; $display("FAIL midreset_outs got grant=%b resp=%b exp 0/0", req_grant, resp_valids()); end
    n_checks++; if (dut.credit !== 4'd8) begin n_fail++; $display("FAIL midreset_credit got=%0d exp=8", dut.credit); end
    #3 reset_n = 1'b1;
    clear_inputs();
    tick();
    req_command[2].valid = 1'b1;
    sample();
    n_checks++; if (req_grant !== 4'b0100) begin n_fail++; $display("FAIL midreset_recover got=%b exp=0100", req_grant); end
    clear_inputs();
  endtask

`ifdef CMD_ARB_TAG_CHECK_EN
  task automatic test_tag_check();
    do_reset();
    tick();
    req_command[0].valid = 1'b1;
    req_command[0].tag   = 8'h03;
    sample();
    n_checks++; if (req_grant !== 4'b0001) begin n_fail++; $display("FAIL tagchk_first got=%b exp=0001", req_grant); end
    tick();
    sample();
    n_checks++; if (req_grant !== 4'b0000 || tag_error !== 1'b0) begin n_fail++; $display("FAIL tagchk_dup got grant=%b err=%b exp 0000/0", req_grant, tag_error); end
    tick(); response.valid = 1'b1; response.tag = 8'h45;
    sample();
    n_checks++; if (resp_valids() !== 4'b0000) begin n_fail++; $display("FAIL tagchk_stray_route got=%b exp=0000", resp_valids()); end
    tick(); response = '0;
    sample();
    n_checks++; if (tag_error !== 1'b1) begin n_fail++; $display("FAIL tagchk_error got=%b exp=1", tag_error); end
    tick(); response.valid = 1'b1; response.tag = 8'h03;
    sample();
    n_checks++; if (resp_valids() !== 4'b0001 || req_response[0].tag !== 8'h03) begin n_fail++; $display("FAIL tagchk_resp got valids=%b tag=%h exp 0001/03", resp_valids(), req_response[0].tag); end
    tick(); response = '0;
    sample();
    n_checks++; if (req_grant !== 4'b0001 || tag_error !== 1'b1) begin n_fail++; $display("FAIL tagchk_regrant got grant=%b err=%b exp 0001/1", req_grant, tag_error); end
    clear_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) req_read_data[i] = '0;
    test_reset();
    test_single();
    test_contention();
    test_credits();
    test_buffer();
    test_drain();
    test_reset_mid();
`ifdef CMD_ARB_TAG_CHECK_EN
    test_tag_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
